// File: rtl/calc_key_entry_pkg.sv
// Shared constants for the calculator key-entry block: operator codes,
// keypad bit positions and the entry FSM state type.
package calc_pkg;

    localparam int NKEYS = 17;

    localparam logic [2:0] OP0     = 3'b000;
    localparam logic [2:0] OP1     = 3'b001;
    localparam logic [2:0] OP2     = 3'b010;
    localparam logic [2:0] OP3     = 3'b011;
    localparam logic [2:0] OP_NONE = 3'b100;

    localparam int KEY_CLR     = 10;
    localparam int KEY_EQ      = 11;
    localparam int KEY_OP_BASE = 12;
    localparam int KEY_BS      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ENTER_A,
        ENTER_B,
        WAIT_BUSY
    } state_t;

endpackage

// File: rtl/calc_key_entry_debounce.sv
// Two-flop synchronizer plus per-vector debouncer for the active-low keypad.
// Emits a one-cycle event with the one-hot pressed key on a clean single press.
module key_debounce #(
    parameter int NKEYS      = 17,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] i_keyb,
    output logic             o_valid,
    output logic [NKEYS-1:0] o_key
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    logic [NKEYS-1:0] r_cand;
    logic [NKEYS-1:0] r_stable;
    logic [CW-1:0]    r_cnt;
    logic             r_armed;
    logic             r_valid;
    logic [NKEYS-1:0] r_key;

    logic          w_same;
    logic [CW-1:0] w_cnt_next;
    logic          w_confirm;
    logic          w_fire;

    assign w_same     = (r_sync2 == r_cand);
    assign w_cnt_next = !w_same ? CW'(1) :
                        (r_cnt == DEB_MAX) ? r_cnt : r_cnt + CW'(1);
    // Confirm only on the cycle the run length first reaches DEB_CYCLES.
    assign w_confirm  = (w_cnt_next == DEB_MAX) && !(w_same && (r_cnt == DEB_MAX));
    assign w_fire     = w_confirm && r_armed && (&r_stable) && $onehot(~r_sync2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_cand   <= '1;
            r_stable <= '1;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_valid  <= 1'b0;
            r_key    <= '0;
        end else begin
            r_sync1 <= i_keyb;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_next;
            r_valid <= w_fire;
            r_key   <= w_fire ? ~r_sync2 : '0;
            if (w_confirm) begin
                r_stable <= r_sync2;
                // A key held through reset stays disarmed until all keys are seen released.
                if (&r_sync2) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_key   = r_key;

endmodule

// File: rtl/calc_key_entry.sv
// Calculator operand entry: turns debounced keypad events into two unsigned
// operands and an operator code, issued downstream with a one-cycle strobe.
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int WIDTH      = 27,
    parameter int MAX_DIGITS = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [16:0]      keyb,
    input  logic             busy_p,
    input  logic             busy_a,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [2:0]       arith,
    output logic             en,
    output logic             ovf
);

    localparam int CNTW = $clog2(MAX_DIGITS + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_DIGITS);

    state_t           r_state;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic [CNTW-1:0]  r_cnt1;
    logic [CNTW-1:0]  r_cnt2;
    logic [2:0]       r_arith;
    logic             r_en;
    logic             r_ovf;

    logic             w_valid;
    logic [NKEYS-1:0] w_key;
    logic             w_evt;
    logic             w_is_digit;
    logic [3:0]       w_digit;
    logic             w_is_op;
    logic [2:0]       w_op_code;
    logic [WIDTH-1:0] w_opnd;
    logic [CNTW-1:0]  w_cnt;
    logic [WIDTH+3:0] w_prod;
    logic [WIDTH-1:0] w_div;
    logic             w_digit_ok;

    key_debounce #(
        .NKEYS      (NKEYS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .i_keyb  (keyb),
        .o_valid (w_valid),
        .o_key   (w_key)
    );

    assign w_evt = w_valid && !busy_p && !busy_a && (r_state != WAIT_BUSY);

    // Key bit i (0..9) is digit 9-i; operator bit KEY_OP_BASE+j carries code 3-j.
    always_comb begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
        w_is_op    = 1'b0;
        w_op_code  = OP_NONE;
        for (int i = 0; i < 10; i++) begin
            if (w_key[i]) begin
                w_is_digit = 1'b1;
                w_digit    = 4'(9 - i);
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (w_key[KEY_OP_BASE + j]) begin
                w_is_op   = 1'b1;
                w_op_code = 3'(3 - j);
            end
        end
    end

    assign w_opnd     = (r_state == ENTER_B) ? r_data2 : r_data1;
    assign w_cnt      = (r_state == ENTER_B) ? r_cnt2 : r_cnt1;
    assign w_prod     = {4'b0, w_opnd} * (WIDTH + 4)'(10) + (WIDTH + 4)'(w_digit);
    assign w_div      = w_opnd / WIDTH'(10);
    assign w_digit_ok = (w_cnt != CNT_MAX) && (w_prod[WIDTH+3:WIDTH] == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data1 <= '0;
            r_data2 <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_arith <= OP_NONE;
            r_en    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_en <= 1'b0;
            if (r_state == WAIT_BUSY) begin
                if (!busy_p && !busy_a) begin
                    r_state <= IDLE;
                end
            end else if (w_evt) begin
                if (w_key[KEY_CLR]) begin
                    r_state <= IDLE;
                    r_data1 <= '0;
                    r_data2 <= '0;
                    r_cnt1  <= '0;
                    r_cnt2  <= '0;
                    r_arith <= OP_NONE;
                    r_ovf   <= 1'b0;
                end else if (w_is_digit) begin
                    if (r_state == IDLE) begin
                        r_state <= ENTER_A;
                        r_data1 <= WIDTH'(w_digit);
                        r_data2 <= '0;
                        r_cnt1  <= CNTW'(1);
                        r_cnt2  <= '0;
                        r_arith <= OP_NONE;
                        r_ovf   <= 1'b0;
                    end else if (!w_digit_ok) begin
                        r_ovf <= 1'b1;
                    end else if (r_state == ENTER_B) begin
                        r_data2 <= w_prod[WIDTH-1:0];
                        r_cnt2  <= r_cnt2 + CNTW'(1);
                    end else begin
                        r_data1 <= w_prod[WIDTH-1:0];
                        r_cnt1  <= r_cnt1 + CNTW'(1);
                    end
                end else if (w_is_op) begin
                    if (r_state != IDLE) begin
                        r_arith <= w_op_code;
                        r_state <= ENTER_B;
                    end
                end else if (w_key[KEY_BS]) begin
                    if (r_state == ENTER_A && r_cnt1 != '0) begin
                        r_data1 <= w_div;
                        r_cnt1  <= r_cnt1 - CNTW'(1);
                    end else if (r_state == ENTER_B) begin
                        if (r_cnt2 != '0) begin
                            r_data2 <= w_div;
                            r_cnt2  <= r_cnt2 - CNTW'(1);
                        end else begin
                            r_arith <= OP_NONE;
                            r_state <= ENTER_A;
                        end
                    end
                end else if (w_key[KEY_EQ]) begin
                    if (r_state != IDLE) begin
                        r_en    <= 1'b1;
                        r_state <= WAIT_BUSY;
                    end
                end
            end
        end
    end

    assign data1 = r_data1;
    assign data2 = r_data2;
    assign arith = r_arith;
    assign en    = r_en;
    assign ovf   = r_ovf;

endmodule

// File: doc/calc_key_entry.md
CALC_KEY_ENTRY -- requirements
Module: calc_key_entry

Interface
REQ-001 Parameter WIDTH, default 27: operand width in bits.
REQ-002 Parameter MAX_DIGITS, default 8: maximum decimal digits per operand.
REQ-003 Parameter DEB_CYCLES, default 4: stable-sample count for debounce (>=1).
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port keyb, input, 17: active-low keys.
  - bit i for i=0..9 is digit 9-i.
  - bit10 = clear; bit11 = equals.
  - bits12..15 = operators with codes 3,2,1,0.
  - bit16 = backspace.
REQ-007 Port busy_p, input, 1: downstream busy (primary).
REQ-008 Port busy_a, input, 1: downstream busy (arithmetic).
REQ-009 Port data1, output, WIDTH: operand A, unsigned binary.
REQ-010 Port data2, output, WIDTH: operand B, unsigned binary.
REQ-011 Port arith, output, 3: operator code; 3'b100 = pass-through (no operator).
REQ-012 Port en, output, 1: one-cycle issue strobe.
REQ-013 Port ovf, output, 1: sticky flag, set when a digit was rejected.

Function
REQ-014 keyb shall pass through a 2-flop synchronizer, then a debouncer.
REQ-015 The debouncer shall update its stable vector only after DEB_CYCLES consecutive identical synchronized samples.
REQ-016 A key event shall fire for one cycle when the stable vector goes from all-ones to exactly one zero bit.
REQ-017 Multi-key patterns and releases shall generate no event; all keys must be released before the next event.
REQ-018 FSM states: IDLE, ENTER_A, ENTER_B, WAIT_BUSY.
REQ-019 Key events shall be ignored in WAIT_BUSY and whenever busy_p or busy_a is high.
REQ-020 Digit d in IDLE: clear data1, data2, counts and ovf; set data1=d, arith=3'b100; go to ENTER_A.
REQ-021 Digit d in ENTER_A or ENTER_B: the active operand shall become operand*10+d, computed at WIDTH+4 bits, and its count shall increment.
  - Rejected instead if count==MAX_DIGITS or the result exceeds 2^WIDTH-1.
  - On rejection: operand unchanged, ovf set.
REQ-022 Operator in ENTER_A: latch arith code, go to ENTER_B.
REQ-023 Operator in ENTER_B: overwrite arith and stay in ENTER_B; data2 unchanged.
REQ-024 Backspace: the active operand shall become operand/10 and its count decrement (no change at count 0).
  - Backspace in ENTER_B at count 0 shall restore arith=3'b100 and return to ENTER_A.
REQ-025 Clear in any state except WAIT_BUSY: zero data1, data2, counts and ovf; arith=3'b100; go to IDLE.
REQ-026 Equals in ENTER_A or ENTER_B shall assert en in the cycle after the event, for exactly one cycle, then go to WAIT_BUSY.
REQ-027 Equals in IDLE shall be ignored.
REQ-028 data1, data2 and arith shall remain stable from the en cycle until the next accepted digit or clear.
REQ-029 WAIT_BUSY shall go to IDLE on the first cycle both busy inputs are low.
  - Busy never rising after en is legal (exit next cycle).
REQ-030 There shall be no combinational path from keyb or the busy inputs to any output; all outputs are registered.

Reset
REQ-031 On rst, all outputs shall be: data1=0, data2=0, arith=3'b100, en=0, ovf=0.
REQ-032 On rst, the FSM shall be IDLE, counts 0, and the synchronizer, debounce counter and stable vector shall be all-ones/idle.
REQ-033 rst mid-entry or during WAIT_BUSY shall take effect the next edge with no en pulse; a key held through reset shall create no event until it is released.

Structure
REQ-034 Package calc_pkg shall hold:
  - arith codes OP0..OP3 and OP_NONE=3'b100;
  - key bit indices KEY_CLR=10, KEY_EQ=11, KEY_OP_BASE=12, KEY_BS=16;
  - the FSM state enum.
REQ-035 Synchronizer and debounce shall live in one sub-module, key_debounce (parameter DEB_CYCLES), outputting event valid plus the one-hot key index.

Verification
REQ-036 Press 1,2,3, op bit13, 4,5, equals -> data1=123, data2=45, arith=3'b010; en high exactly one cycle; en rises one cycle after equals is accepted.
REQ-037 With MAX_DIGITS=8, press 9 nine times -> data1=99999999, ovf=1.
  - With WIDTH=8, press 2,5,6 -> data1=25, ovf=1.
REQ-038 Glitch a digit key low for DEB_CYCLES-1 cycles -> no change; hold it for DEB_CYCLES+2 cycles -> exactly one digit accepted.
REQ-039 Issue 7, equals, then hold busy_a=1 for 20 cycles while pressing 5 -> 5 ignored, data1 stays 7; after busy drops, pressing 3 -> data1=3, data2=0.
REQ-040 Enter 12, op, 3, backspace, backspace -> ENTER_A with data1=12, arith=3'b100.
  - Then assert rst with key 4 held -> all outputs at reset values, and no event until 4 is released and pressed again.
